// File: rtl/uart_route_switch.sv
// uart_route_switch: N-output UART router with a programmable routing mask.
// In prog mode a received UART frame loads the mask; in data mode sin is
// forwarded (registered) to every output whose mask bit is set. The mode and
// the forwarding mask are latched at start detection, so a prog change never
// splits a frame.
// Optional feature macro: UART_ROUTE_SWITCH_PARITY_EN (8E1 frames with an
// even-parity bit; undefined = 8N1 only).
//
// state  | meaning
// IDLE   | line idle, watching sin_q for a start bit
// START  | half-bit wait, then confirm the start bit at its middle
// DATA   | sample 8 data bits LSB first, one per bit period
// PARITY | sample the even-parity bit (parity build only)
// STOP   | sample the stop bit, commit config or report a frame error

module uart_route_switch #(
  parameter int NUM_OUT      = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int RESET_MASK   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               prog,
  input  logic               sin,
  output logic [NUM_OUT-1:0] sout,
  output logic [NUM_OUT-1:0] mask,
  output logic               cfg_valid,
  output logic               frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]      HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]      BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [NUM_OUT-1:0] MASK_INIT = NUM_OUT'(RESET_MASK);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t             state;
  logic               sin_q;
  logic               mode_q;
  logic [NUM_OUT-1:0] mask_f;
  logic [CW-1:0]      cnt;
  logic [2:0]         bit_cnt;
  logic [7:0]         shift;
`ifdef UART_ROUTE_SWITCH_PARITY_EN
  logic               par_err;
`endif

  logic               cfg_now;
  logic [NUM_OUT-1:0] fwd_mask;
  logic               frame_ok;

  // Forwarding mode/mask for this cycle; in IDLE a start edge already counts
  // as the new frame so a config frame never leaks its start bit.
  always_comb begin
    cfg_now  = mode_q;
    fwd_mask = mask_f;
    if (state == IDLE) begin
      cfg_now  = prog & ~sin_q;
      fwd_mask = mask;
    end
`ifdef UART_ROUTE_SWITCH_PARITY_EN
    frame_ok = sin_q & ~par_err;
`else
    frame_ok = sin_q;
`endif
  end

  // Receiver FSM, bit timing, mask register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sin_q     <= 1'b1;
      mode_q    <= 1'b0;
      mask_f    <= MASK_INIT;
      mask      <= MASK_INIT;
      cnt       <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      sout      <= '1;
      cfg_valid <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_ROUTE_SWITCH_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      sin_q     <= sin;
      cfg_valid <= 1'b0;
      frame_err <= 1'b0;
      sout      <= cfg_now ? '1 : (~fwd_mask | {NUM_OUT{sin_q}});

      case (state)
        IDLE: begin
          if (!sin_q) begin
            mode_q  <= prog;
            mask_f  <= mask;
            bit_cnt <= '0;
            cnt     <= HALF_LOAD;
            state   <= START;
`ifdef UART_ROUTE_SWITCH_PARITY_EN
            par_err <= 1'b0;
`endif
          end
        end
        START: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (sin_q) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt   <= BIT_LOAD;
            state <= DATA;
          end
        end
        DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            shift   <= {sin_q, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            cnt     <= BIT_LOAD;
            if (bit_cnt == 3'd7) begin
`ifdef UART_ROUTE_SWITCH_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_ROUTE_SWITCH_PARITY_EN
        PARITY: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            par_err <= sin_q ^ (^shift);
            cnt     <= BIT_LOAD;
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            state <= IDLE;
            if (frame_ok) begin
              if (mode_q) begin
                mask      <= shift[NUM_OUT-1:0];
                cfg_valid <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_route_switch.sv
// Directed bench for uart_route_switch (NUM_OUT=4, CLKS_PER_BIT=16).
// Inputs are driven on the falling edge, outputs observed on the falling edge
// just before the next drive. Build with UART_ROUTE_SWITCH_PARITY_EN defined
// to also exercise the parity frames.

module tb_uart_route_switch;

  localparam int N   = 4;
  localparam int CPB = 16;
`ifdef UART_ROUTE_SWITCH_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // observation index (relative to the first low drive) of the stop-sample pulse
  localparam int STOP_REL  = 2 + CPB / 2 + (NBITS - 1) * CPB;
  localparam int START_REL = 2 + CPB / 2;
  localparam int GAP       = 40;

  logic         clk = 1'b0;
  logic         rst;
  logic         prog;
  logic         sin;
  logic [N-1:0] sout;
  logic [N-1:0] mask;
  logic         cfg_valid;
  logic         frame_err;

  int           n_vec;
  int           n_bad;
  logic         d1, d2;
  logic [N-1:0] exp_en;
  logic         exp_hi;
  int           rel, obs_bad, cfg_cnt, err_cnt, cfg_rel, err_rel;

  uart_route_switch #(.NUM_OUT(N), .CLKS_PER_BIT(CPB), .RESET_MASK(1)) dut (
    .clk(clk), .rst(rst), .prog(prog), .sin(sin),
    .sout(sout), .mask(mask), .cfg_valid(cfg_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // One bit-time slice: record what the outputs did, then drive sin.
  // sout at this edge must equal the sin driven two falling edges ago.
  task automatic step(input logic b);
    @(negedge clk);
    if (sout !== (exp_hi ? {N{1'b1}} : (~exp_en | {N{d2}}))) obs_bad++;
    if (cfg_valid === 1'b1 && frame_err === 1'b1) obs_bad++;
    if (cfg_valid === 1'b1) begin
      if (cfg_cnt == 0) cfg_rel = rel;
      cfg_cnt++;
    end
    if (frame_err === 1'b1) begin
      if (err_cnt == 0) err_rel = rel;
      err_cnt++;
    end
    d2  = d1;
    d1  = b;
    sin = b;
    rel++;
  endtask

  task automatic clear_mon();
    obs_bad = 0; cfg_cnt = 0; err_cnt = 0; cfg_rel = -1; err_rel = -1; rel = 0;
  endtask

  function automatic logic frame_bit(input logic [7:0] data, input logic pbit,
                                     input logic sbit, input int r);
    int b;
    b = r / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return data[b-1];
`ifdef UART_ROUTE_SWITCH_PARITY_EN
    if (b == 9) return pbit;
    if (b == 10) return sbit;
`else
    if (b == 9) return sbit;
`endif
    return 1'b1;
  endfunction

  task automatic send_frame(input logic [7:0] data, input logic pbit, input logic sbit,
                            input int prog_rel, input logic prog_new);
    clear_mon();
    for (int r = 0; r < NBITS * CPB + GAP; r++) begin
      if (r == prog_rel) prog = prog_new;
      step(frame_bit(data, pbit, sbit, r));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; prog = 1'b0; sin = 1'b1; d1 = 1'b1; d2 = 1'b1;
    exp_en = 4'b0001; exp_hi = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (sout !== 4'b1111) begin n_bad++; $display("FAIL reset_sout got %b want 1111", sout); end
    n_vec++; if (mask !== 4'b0001) begin n_bad++; $display("FAIL reset_mask got %b want 0001", mask); end
    n_vec++; if (cfg_valid !== 1'b0) begin n_bad++; $display("FAIL reset_cfg_valid got %b want 0", cfg_valid); end
    n_vec++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
  endtask

  task automatic test_data_a5();
    prog = 1'b0; exp_hi = 1'b0; exp_en = 4'b0001;
    send_frame(8'hA5, ^8'hA5, 1'b1, -1, 1'b0);
    n_vec++; if (obs_bad !== 0) begin n_bad++; $display("FAIL a5_forward got %0d bad cycles want 0", obs_bad); end
    n_vec++; if (cfg_cnt !== 0) begin n_bad++; $display("FAIL a5_cfg got %0d pulses want 0", cfg_cnt); end
    n_vec++; if (err_cnt !== 0) begin n_bad++; $display("FAIL a5_err got %0d pulses want 0", err_cnt); end
    n_vec++; if (mask !== 4'b0001) begin n_bad++; $display("FAIL a5_mask got %b want 0001", mask); end
  endtask

  task automatic test_config_0c();
    prog = 1'b1; exp_hi = 1'b1;
    send_frame(8'h0C, ^8'h0C, 1'b1, -1, 1'b0);
    n_vec++; if (obs_bad !== 0) begin n_bad++; $display("FAIL cfg0c_outputs got %0d bad cycles want 0", obs_bad); end
    n_vec++; if (cfg_cnt !== 1) begin n_bad++; $display("FAIL cfg0c_cfg_count got %0d want 1", cfg_cnt); end
    n_vec++; if (cfg_rel !== STOP_REL) begin n_bad++; $display("FAIL cfg0c_cfg_time got %0d want %0d", cfg_rel, STOP_REL); end
    n_vec++; if (err_cnt !== 0) begin n_bad++; $display("FAIL cfg0c_err got %0d want 0", err_cnt); end
    n_vec++; if (mask !== 4'b1100) begin n_bad++; $display("FAIL cfg0c_mask got %b want 1100", mask); end
  endtask

  task automatic test_data_3c();
    prog = 1'b0; exp_hi = 1'b0; exp_en = 4'b1100;
    send_frame(8'h3C, ^8'h3C, 1'b1, -1, 1'b0);
    n_vec++; if (obs_bad !== 0) begin n_bad++; $display("FAIL d3c_forward got %0d bad cycles want 0", obs_bad); end
    n_vec++; if (err_cnt !== 0) begin n_bad++; $display("FAIL d3c_err got %0d want 0", err_cnt); end
    n_vec++; if (cfg_cnt !== 0) begin n_bad++; $display("FAIL d3c_cfg got %0d want 0", cfg_cnt); end
  endtask

  task automatic test_bad_stop();
    prog = 1'b1; exp_hi = 1'b1;
    send_frame(8'h0F, ^8'h0F, 1'b0, -1, 1'b0);
    n_vec++; if (err_rel !== STOP_REL) begin n_bad++; $display("FAIL badstop_err_time got %0d want %0d", err_rel, STOP_REL); end
    n_vec++; if (cfg_cnt !== 0) begin n_bad++; $display("FAIL badstop_cfg got %0d want 0", cfg_cnt); end
    n_vec++; if (mask !== 4'b1100) begin n_bad++; $display("FAIL badstop_mask got %b want 1100", mask); end
    n_vec++; if (obs_bad !== 0) begin n_bad++; $display("FAIL badstop_outputs got %0d bad cycles want 0", obs_bad); end
  endtask

  task automatic test_glitch();
    prog = 1'b0; exp_hi = 1'b0; exp_en = 4'b1100;
    clear_mon();
    for (int r = 0; r < 40; r++) step(r < 3 ? 1'b0 : 1'b1);
    n_vec++; if (err_cnt !== 1) begin n_bad++; $display("FAIL glitch_err_count got %0d want 1", err_cnt); end
    n_vec++; if (err_rel !== START_REL) begin n_bad++; $display("FAIL glitch_err_time got %0d want %0d", err_rel, START_REL); end
    n_vec++; if (obs_bad !== 0) begin n_bad++; $display("FAIL glitch_outputs got %0d bad cycles want 0", obs_bad); end
    n_vec++; if (mask !== 4'b1100) begin n_bad++; $display("FAIL glitch_mask got %b want 1100", mask); end
    n_vec++; if (cfg_cnt !== 0) begin n_bad++; $display("FAIL glitch_cfg got %0d want 0", cfg_cnt); end
  endtask

  task automatic test_prog_mid_frame();
    prog = 1'b0; exp_hi = 1'b0; exp_en = 4'b1100;
    send_frame(8'h5A, ^8'h5A, 1'b1, 4 * CPB, 1'b1);
    n_vec++; if (obs_bad !== 0) begin n_bad++; $display("FAIL midprog_forward got %0d bad cycles want 0", obs_bad); end
    n_vec++; if (cfg_cnt !== 0) begin n_bad++; $display("FAIL midprog_cfg got %0d want 0", cfg_cnt); end
    n_vec++; if (mask !== 4'b1100) begin n_bad++; $display("FAIL midprog_mask got %b want 1100", mask); end
    exp_hi = 1'b1;
    send_frame(8'h06, ^8'h06, 1'b1, -1, 1'b0);
    n_vec++; if (cfg_cnt !== 1) begin n_bad++; $display("FAIL nextcfg_cfg got %0d want 1", cfg_cnt); end
    n_vec++; if (mask !== 4'b0110) begin n_bad++; $display("FAIL nextcfg_mask got %b want 0110", mask); end
    n_vec++; if (obs_bad !== 0) begin n_bad++; $display("FAIL nextcfg_outputs got %0d bad cycles want 0", obs_bad); end
  endtask

  task automatic test_reset_mid_frame();
    prog = 1'b1; exp_hi = 1'b1;
    clear_mon();
    for (int r = 0; r < 6 * CPB; r++) step(frame_bit(8'h02, ^8'h02, 1'b1, r));
    @(negedge clk);
    rst = 1'b1; sin = 1'b1;
    @(negedge clk);
    n_vec++; if (mask !== 4'b0001) begin n_bad++; $display("FAIL rstmid_mask got %b want 0001", mask); end
    n_vec++; if (sout !== 4'b1111) begin n_bad++; $display("FAIL rstmid_sout got %b want 1111", sout); end
    n_vec++; if (cfg_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_cfg_valid got %b want 0", cfg_valid); end
    rst = 1'b0; d1 = 1'b1; d2 = 1'b1;
    exp_hi = 1'b0; exp_en = 4'b0001;
    clear_mon();
    repeat (NBITS * CPB) step(1'b1);
    n_vec++; if (cfg_cnt !== 0) begin n_bad++; $display("FAIL rstmid_late_cfg got %0d want 0", cfg_cnt); end
    n_vec++; if (mask !== 4'b0001) begin n_bad++; $display("FAIL rstmid_late_mask got %b want 0001", mask); end
    n_vec++; if (obs_bad !== 0) begin n_bad++; $display("FAIL rstmid_outputs got %0d bad cycles want 0", obs_bad); end
  endtask

`ifdef UART_ROUTE_SWITCH_PARITY_EN
  task automatic test_parity();
    prog = 1'b1; exp_hi = 1'b1;
    send_frame(8'h03, 1'b1, 1'b1, -1, 1'b0);
    n_vec++; if (err_rel !== STOP_REL) begin n_bad++; $display("FAIL par_cfg_err_time got %0d want %0d", err_rel, STOP_REL); end
    n_vec++; if (cfg_cnt !== 0) begin n_bad++; $display("FAIL par_cfg_cfg got %0d want 0", cfg_cnt); end
    n_vec++; if (mask !== 4'b0001) begin n_bad++; $display("FAIL par_cfg_mask got %b want 0001", mask); end
    prog = 1'b0; exp_hi = 1'b0; exp_en = 4'b0001;
    send_frame(8'hA5, ~(^8'hA5), 1'b1, -1, 1'b0);
    n_vec++; if (obs_bad !== 0) begin n_bad++; $display("FAIL par_data_forward got %0d bad cycles want 0", obs_bad); end
    n_vec++; if (err_cnt !== 1) begin n_bad++; $display("FAIL par_data_err got %0d want 1", err_cnt); end
  endtask
`endif

  initial begin
    n_vec = 0; n_bad = 0;
    clear_mon();
    test_reset();
    test_data_a5();
    test_config_0c();
    test_data_3c();
    test_bad_stop();
    test_glitch();
    test_prog_mid_frame();
    test_reset_mid_frame();
`ifdef UART_ROUTE_SWITCH_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
